// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
// Run/load controller for the 1-bit CPU. It owns the CPU's bit-wide program
// memory and gives the host write access while in LOAD and the CPU fetch
// access otherwise. It sequences the CPU reset and clock-enable to provide
// HALT, RUN and single-STEP operation, and counts the cycles the CPU executes.
//
// Ports
//   clk        clock, all logic on the rising edge
//   n_rst      synchronous reset, active-high
//   cmd_valid  command strobe
//   cmd        0=HALT 1=RUN 2=STEP 3=LOAD
//   cmd_ready  command accepted when cmd_valid && cmd_ready
//   wr_valid   host program-write request
//   wr_ready   high only in LOAD
//   wr_addr    program write address
//   wr_data    program write bit
//   cpu_addr   fetch address from the CPU
//   cpu_data   mem[cpu_addr], combinational read
//   cpu_rst    registered active-high reset to the CPU
//   cpu_en     registered CPU clock-enable
//   busy       high in RST, RUN or STEP
//   cycle_cnt  saturating count of cpu_en cycles since the last RST
// -----------------------------------------------------------------------------
module cpu_run_ctrl #(
    parameter int unsigned ADDR_W  = 1,
    parameter int unsigned RST_CYC = 2,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd,
    output logic              cmd_ready,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_data,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_data,
    output logic              cpu_rst,
    output logic              cpu_en,
    output logic              busy,
    output logic [CNT_W-1:0]  cycle_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned RC_W  = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    localparam logic [RC_W-1:0]  RST_LAST = RC_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    localparam logic [1:0] CMD_HALT = 2'd0;
    localparam logic [1:0] CMD_RUN  = 2'd1;
    localparam logic [1:0] CMD_STEP = 2'd2;
    localparam logic [1:0] CMD_LOAD = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRst,
        StRun,
        StStep
    } state_e;

    state_e             state_q, state_d;
    logic               tgt_step_q, tgt_step_d;   // state to enter after RST: 1=STEP, 0=RUN
    logic               started_q, started_d;     // CPU has been reset since the last load
    logic [RC_W-1:0]    rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cpu_rst_q, cpu_rst_d;
    logic               cpu_en_q, cpu_en_d;
    logic [DEPTH-1:0]   mem_q;

    logic               cmd_go;
    logic               mem_we;
    logic               rst_entry;

    // ------------------------------------------------------------------
    // Handshake and status outputs, decoded from the current state
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            StIdle: cmd_ready = 1'b1;
            StLoad: begin
                cmd_ready = 1'b1;
                wr_ready  = 1'b1;
            end
            StRst:  busy = 1'b1;
            StRun: begin
                cmd_ready = 1'b1;
                busy      = 1'b1;
            end
            StStep: busy = 1'b1;
            default: ;
        endcase
    end

    assign cmd_go    = cmd_valid && cmd_ready;
    assign mem_we    = wr_valid && wr_ready;
    assign cpu_data  = mem_q[cpu_addr];
    assign cpu_rst   = cpu_rst_q;
    assign cpu_en    = cpu_en_q;
    assign cycle_cnt = cnt_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        tgt_step_d = tgt_step_q;
        started_d  = started_q;
        rst_cnt_d  = rst_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_go) begin
                    case (cmd)
                        CMD_LOAD: state_d = StLoad;
                        CMD_RUN: begin
                            state_d    = StRst;
                            tgt_step_d = 1'b0;
                            rst_cnt_d  = '0;
                        end
                        CMD_STEP: begin
                            // A CPU that was already reset steps directly.
                            if (started_q) begin
                                state_d = StStep;
                            end else begin
                                state_d    = StRst;
                                tgt_step_d = 1'b1;
                                rst_cnt_d  = '0;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            StLoad: begin
                if (cmd_go && cmd != CMD_LOAD) begin
                    // New program contents invalidate the CPU's state.
                    started_d = 1'b0;
                    case (cmd)
                        CMD_HALT: state_d = StIdle;
                        CMD_RUN: begin
                            state_d    = StRst;
                            tgt_step_d = 1'b0;
                            rst_cnt_d  = '0;
                        end
                        default: begin
                            state_d    = StRst;
                            tgt_step_d = 1'b1;
                            rst_cnt_d  = '0;
                        end
                    endcase
                end
            end

            StRst: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d   = tgt_step_q ? StStep : StRun;
                    started_d = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q + RC_W'(1);
                end
            end

            StRun: begin
                // Only HALT has an effect while running.
                if (cmd_go && cmd == CMD_HALT) begin
                    state_d = StIdle;
                end
            end

            StStep: state_d = StIdle;

            default: state_d = StIdle;
        endcase
    end

    assign rst_entry = (state_d == StRst) && (state_q != StRst);

    // ------------------------------------------------------------------
    // Registered CPU controls follow the next state so they line up with it
    // ------------------------------------------------------------------
    always_comb begin
        cpu_rst_d = 1'b0;
        cpu_en_d  = 1'b0;
        unique case (state_d)
            StIdle, StLoad: cpu_rst_d = ~started_d;
            StRst:          cpu_rst_d = 1'b1;
            StRun, StStep:  cpu_en_d  = 1'b1;
            default:        cpu_rst_d = 1'b1;
        endcase
    end

    // Executed-cycle counter: cleared on RST entry, saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (rst_entry) begin
            cnt_d = '0;
        end else if (cpu_en_q && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // State registers and program memory
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q    <= StIdle;
            tgt_step_q <= 1'b0;
            started_q  <= 1'b0;
            rst_cnt_q  <= '0;
            cnt_q      <= '0;
            cpu_rst_q  <= 1'b1;
            cpu_en_q   <= 1'b0;
            mem_q      <= '0;
        end else begin
            state_q    <= state_d;
            tgt_step_q <= tgt_step_d;
            started_q  <= started_d;
            rst_cnt_q  <= rst_cnt_d;
            cnt_q      <= cnt_d;
            cpu_rst_q  <= cpu_rst_d;
            cpu_en_q   <= cpu_en_d;
            if (mem_we) begin
                mem_q[wr_addr] <= wr_data;
            end
        end
    end

endmodule
